// File: rtl/rr_arbiter4_if.sv
// Handshake bundle between four requesting agents and the rr_arbiter4 grant logic.
// The master side belongs to the agents; the slave side belongs to the arbiter.
interface rr_arbiter4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, preempt
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. A grant is held until its owner drops req or
// MAX_HOLD cycles elapse, and every release is followed by one dead cycle.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter4_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t     state, state_nx;
    logic [1:0] last, last_nx;
    logic [1:0] idx, idx_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic       valid_nx;
    logic       preempt_nx;
    logic [3:0] gnt_nx;

    logic       found;
    logic [1:0] winner;

    // Search starts just after the previous owner, so the previous owner is tried last.
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
    // registers elsewhere use '<=' so every flop samples pre-edge values.
    always_comb begin
        found  = 1'b0;
        winner = last;
        for (int k = 1; k <= 4; k++) begin
            if (!found && bus.req[last + 2'(k)]) begin
                found  = 1'b1;
                winner = last + 2'(k);
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch can be inferred.
    always_comb begin
        state_nx   = state;
        last_nx    = last;
        idx_nx     = idx;
        hold_nx    = hold_cnt;
        valid_nx   = bus.gnt_valid;
        preempt_nx = 1'b0;

        unique case (state)
            IDLE, GAP: begin
                if (bus.en && found) begin
                    state_nx = GRANT;
                    idx_nx   = winner;
                    last_nx  = winner;
                    hold_nx  = 8'd0;
                    valid_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end

            GRANT: begin
                // A voluntary release takes precedence over a coincident timeout.
                if (!bus.req[idx]) begin
                    state_nx = GAP;
                    valid_nx = 1'b0;
                end else if (TIMEOUT_EN && hold_cnt == HOLD_LAST) begin
                    state_nx   = GAP;
                    valid_nx   = 1'b0;
                    preempt_nx = 1'b1;
                end else if (hold_cnt != 8'hFF) begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end

            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase

        gnt_nx = valid_nx ? (4'b0001 << idx_nx) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= 2'd3;
            idx           <= 2'd0;
            hold_cnt      <= 8'd0;
            bus.gnt       <= 4'b0000;
            bus.gnt_idx   <= 2'd0;
            bus.gnt_valid <= 1'b0;
            bus.preempt   <= 1'b0;
        end else begin
            state         <= state_nx;
            last          <= last_nx;
            idx           <= idx_nx;
            hold_cnt      <= hold_nx;
            bus.gnt       <= gnt_nx;
            bus.gnt_idx   <= idx_nx;
            bus.gnt_valid <= valid_nx;
            bus.preempt   <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (MAX_HOLD 16, 4, 0) share one stimulus stream
// and are each compared every cycle against an ownership-level model of the arbiter.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_arbiter4_if if16 ();
    rr_arbiter4_if if4 ();
    rr_arbiter4_if if0 ();

    assign if16.en = en;
    assign if16.req = req;
    assign if4.en  = en;
    assign if4.req  = req;
    assign if0.en  = en;
    assign if0.req  = req;

    rr_arbiter4 #(.MAX_HOLD(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    rr_arbiter4 #(.MAX_HOLD(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    rr_arbiter4 #(.MAX_HOLD(0))  u_dut0  (.clk(clk), .rst(rst), .bus(if0));

    logic [3:0] o_gnt   [3];
    logic [1:0] o_idx   [3];
    logic       o_valid [3];
    logic       o_pre   [3];

    assign o_gnt[0] = if16.gnt;  assign o_idx[0] = if16.gnt_idx;
    assign o_gnt[1] = if4.gnt;   assign o_idx[1] = if4.gnt_idx;
    assign o_gnt[2] = if0.gnt;   assign o_idx[2] = if0.gnt_idx;
    assign o_valid[0] = if16.gnt_valid;  assign o_pre[0] = if16.preempt;
    assign o_valid[1] = if4.gnt_valid;   assign o_pre[1] = if4.preempt;
    assign o_valid[2] = if0.gnt_valid;   assign o_pre[2] = if0.preempt;

    // Model: who owns the resource, for how many completed cycles, and who owned it last.
    int m_max   [3] = '{16, 4, 0};
    bit m_own   [3];
    int m_idx   [3];
    int m_last  [3];
    int m_held  [3];
    bit m_pre   [3];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i);
        bit picked;
        if (rst) begin
            m_own[i]  = 1'b0;
            m_idx[i]  = 0;
            m_last[i] = 3;
            m_held[i] = 0;
            m_pre[i]  = 1'b0;
        end else if (m_own[i]) begin
            m_held[i]++;
            m_pre[i] = 1'b0;
            if (!req[m_idx[i]]) begin
                m_own[i] = 1'b0;
            end else if (m_max[i] != 0 && m_held[i] >= m_max[i]) begin
                m_own[i] = 1'b0;
                m_pre[i] = 1'b1;
            end
        end else begin
            m_pre[i] = 1'b0;
            picked   = 1'b0;
            if (en && req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int a;
                    a = (m_last[i] + k) % 4;
                    if (!picked && req[a]) begin
                        picked    = 1'b1;
                        m_own[i]  = 1'b1;
                        m_idx[i]  = a;
                        m_last[i] = a;
                        m_held[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] exp_gnt;
        logic [3:0] g;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_gnt = m_own[i] ? (4'b0001 << m_idx[i]) : 4'b0000;
            g = o_gnt[i];
            check($sformatf("gnt[%0d]", i),       8'(o_gnt[i]),   8'(exp_gnt));
            check($sformatf("gnt_idx[%0d]", i),   8'(o_idx[i]),   8'(m_idx[i]));
            check($sformatf("gnt_valid[%0d]", i), 8'(o_valid[i]), 8'(m_own[i]));
            check($sformatf("preempt[%0d]", i),   8'(o_pre[i]),   8'(m_pre[i]));
            check($sformatf("onehot[%0d]", i),    8'({$onehot0(g), g[o_idx[i]]}),
                  8'({1'b1, o_valid[i]}));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        check("reset_gnt", 8'(if16.gnt), 8'h00);
        rst = 1'b0;

        // Single request, grant latency and release into GAP then IDLE.
        en  = 1'b1;
        req = 4'b0100;
        tick();
        check("single_gnt", 8'(if16.gnt), 8'h04);
        check("single_idx", 8'(if16.gnt_idx), 8'h02);
        repeat (3) tick();
        req = 4'b0000;
        tick();
        check("single_release", 8'(if16.gnt), 8'h00);
        tick();

        // All four requesting, each owner leaves after three cycles: order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_order_%0d", k), 8'(if16.gnt_idx), 8'(k % 4));
            check($sformatf("rr_valid_%0d", k), 8'(if16.gnt_valid), 8'h01);
            tick();
            tick();
            req[k % 4] = 1'b0;
            tick();
            check($sformatf("rr_gap_%0d", k), 8'(if16.gnt), 8'h00);
            req = 4'b1111;
            tick();
        end

        // Timeout with two contenders on the MAX_HOLD=4 instance.
        do_reset();
        req = 4'b0011;
        tick();
        check("to_first", 8'(if4.gnt), 8'h01);
        repeat (3) tick();
        check("to_still", 8'(if4.gnt), 8'h01);
        tick();
        check("to_preempt", 8'(if4.preempt), 8'h01);
        check("to_gap", 8'(if4.gnt), 8'h00);
        tick();
        check("to_next", 8'(if4.gnt), 8'h02);
        check("to_pulse", 8'(if4.preempt), 8'h00);
        repeat (12) tick();

        // en=0 blocks new grants but not an active one.
        do_reset();
        en  = 1'b0;
        req = 4'b1000;
        repeat (10) tick();
        check("en_block", 8'(if16.gnt), 8'h00);
        en  = 1'b1;
        req = 4'b0010;
        tick();
        en = 1'b0;
        repeat (6) tick();
        check("en_keep", 8'(if16.gnt), 8'h02);
        req = 4'b1000;
        repeat (4) tick();
        check("en_no_new", 8'(if16.gnt), 8'h00);
        en = 1'b1;

        // Reset during an active grant.
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b1111;
        tick();
        rst = 1'b1;
        tick();
        check("rst_cut", 8'(if16.gnt), 8'h00);
        check("rst_pre", 8'(if16.preempt), 8'h00);
        rst = 1'b0;
        tick();
        check("rst_agent0", 8'(if16.gnt), 8'h01);

        // Long single-agent hold: no timeout on MAX_HOLD=0, repeats on the others.
        do_reset();
        req = 4'b0001;
        repeat (300) tick();
        check("long_hold", 8'(if0.gnt), 8'h01);

        // Randomised traffic.
        do_reset();
        req = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) req[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(15) == 0) en = ~en;
            rst = ($urandom_range(199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with hold and timeout.
- Shares one resource (bus, memory port, decoder-driven select line) between four agents.
- Each grant is held until the owner drops its request or a hold timeout expires.
- Drives a one-hot grant (2-to-4 decode of the registered winner index) plus the encoded index, so downstream selects need no separate decode.

Parameters:
- MAX_HOLD, 16: maximum consecutive GRANT cycles before forced release. Range 0..255; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  arbitration enable; 0 blocks new grants only
- req  input  4  request per agent; level, held while resource is wanted
- gnt  output  4  one-hot grant, registered; all-zero when no owner
- gnt_idx  output  2  encoded index of current/last owner, registered
- gnt_valid  output  1  1 when gnt is nonzero
- preempt  output  1  one-cycle pulse when a grant ends by timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0.
  - State=IDLE, last=3 (agent 0 has top priority first), hold_cnt=0.
  - rst overrides everything, including an active grant; gnt drops at that edge.
- States:
  - IDLE: no owner, no recent release.
  - GRANT: one owner.
  - GAP: one mandatory dead cycle after every release.
- Arbitration, done in IDLE and GAP:
  - Fires only if en=1 and req!=0.
  - Search order is (last+1), (last+2), (last+3), last, mod 4. First asserted req wins.
  - Next edge: state=GRANT, gnt_idx=winner, gnt=decode(winner), gnt_valid=1, last=winner, hold_cnt=0.
- Latency: req sampled at edge N gives gnt at edge N+1. One cycle from IDLE.
- IDLE: stays in IDLE if en=0 or req=0.
- GRANT: hold_cnt increments each cycle, saturating at 255.
  - Release when req[gnt_idx]=0: next edge gnt=0000, gnt_valid=0, state=GAP, preempt=0.
  - Timeout when MAX_HOLD!=0, req[gnt_idx]=1 and hold_cnt==MAX_HOLD-1: next edge gnt=0000, gnt_valid=0, state=GAP, preempt=1 for exactly one cycle.
  - If both release and timeout conditions hold in the same cycle, it is a release and preempt=0.
  - Requests from other agents do not affect the current grant.
  - en=0 does not cut an active grant.
  - Otherwise stays in GRANT with outputs unchanged.
- GAP: gnt=0000 for exactly one cycle.
  - Arbitrates as above. Winner granted at the next edge, so grant-to-grant spacing is at least one dead cycle.
  - If en=0 or req=0, next state is IDLE.
- Fairness:
  - A preempted agent that still requests becomes lowest priority.
  - With all four requesting continuously, the order is 0,1,2,3,0,…
- gnt_idx retains the last owner while gnt_valid=0.
- gnt is always zero or exactly one-hot, and gnt[gnt_idx]==gnt_valid.
- preempt is 0 in all states except the single cycle after a timeout.
- Single-agent repeat: req stays 0001 through a timeout → agent 0 is re-granted after the GAP cycle (no other contender).

Test Plan:
- Reset, en=1, req=0100 at edge 1 → edge 2: gnt=0100, gnt_idx=10, gnt_valid=1. req=0000 at edge 5 → edge 6: gnt=0000, state GAP. Edge 7: IDLE.
- Reset, req=1111, each owner drops its req 3 cycles after grant and reasserts after GAP → grant order 0,1,2,3,0. Every handover separated by one all-zero gnt cycle.
- MAX_HOLD=4, req=0011 held → agent 0 owns 4 cycles, then preempt=1 with gnt=0000, then agent 1 owns 4 cycles, then agent 0 again.
- en=0 with req=1000 → gnt stays 0000 indefinitely. en=0 during an active grant to agent 1 → agent 1 keeps gnt until its req drops, then no new grant.
- rst=1 while agent 2 owns, req=1111 held → next edge gnt=0000, preempt=0. After rst drops, agent 0 wins first (last=3).
- MAX_HOLD=0, req=0001 held 300 cycles → gnt=0001 continuously, preempt never asserts, hold_cnt saturates with no wrap effect.
